// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq
//   Power-up and re-lock sequencer for a PLL. It drives the PLL reset and
//   watches the PLL lock output through a two-flop synchronizer. The
//   downstream reset (sys_rst_n) is released only after lock has stayed high
//   for LOCK_STABLE_CYC consecutive cycles. A lock timeout triggers another
//   PLL reset. MAX_RETRY consecutive timeouts park the block in FAIL until
//   software restarts it. Lock drops seen while running are counted.
//
// Ports
//   clk           in   free-running reference clock (same source as PLL clkin)
//   rst_n         in   asynchronous active-low reset
//   pll_lock      in   PLL lock, asynchronous to clk
//   sw_rst_req    in   single-cycle software restart request (wins over all)
//   pll_rst       out  PLL reset, active high
//   sys_rst_n     out  downstream reset, active low, high only in RUN
//   pll_fail      out  set while parked in FAIL (retries exhausted)
//   state         out  FSM state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL
//   lock_loss_cnt out  saturating count of lock drops seen in RUN
module pll_lock_rst_seq #(
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_TIMEOUT_CYC = 5000,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             sw_rst_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             pll_fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_A   = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYC) ? MAX_A : LOCK_STABLE_CYC;
  // The shared cycle counter only has to reach MAX_CYC-1.
  localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam int RW      = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [RW-1:0]    retry_inc;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             pll_fail_q, pll_fail_d;
  logic             sync1_q, sync2_q;
  logic             lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s    = sync2_q;
  assign retry_inc = retry_q + RW'(1);

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (sw_rst_req) begin
      // Software restart: the loss counter is deliberately left alone.
      state_d = ST_PLL_RST;
      tmr_d   = TW'(0);
      retry_d = RW'(0);
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (tmr_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            tmr_d   = TW'(0);
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            tmr_d   = TW'(0);
          end else if (tmr_q == TO_LAST) begin
            tmr_d   = TW'(0);
            retry_d = retry_inc;
            if (retry_inc == RETRY_LIMIT) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PLL_RST;
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        ST_STABLE: begin
          // A lock glitch restarts the wait without consuming a retry.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            tmr_d   = TW'(0);
          end else if (tmr_q == STABLE_LAST) begin
            state_d = ST_RUN;
            tmr_d   = TW'(0);
            retry_d = RW'(0);
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PLL_RST;
            tmr_d   = TW'(0);
            if (loss_q == {CNT_W{1'b1}}) begin
              loss_d = loss_q;
            end else begin
              loss_d = loss_q + CNT_W'(1);
            end
          end else begin
            tmr_d = TW'(0);
          end
        end
        ST_FAIL: begin
          tmr_d = TW'(0);
        end
        default: begin
          state_d = ST_PLL_RST;
          tmr_d   = TW'(0);
          retry_d = RW'(0);
        end
      endcase
    end
    // Outputs are decoded from the next state so they move with state.
    pll_rst_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    sys_rst_n_d = (state_d == ST_RUN);
    pll_fail_d  = (state_d == ST_FAIL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      tmr_q       <= TW'(0);
      retry_q     <= RW'(0);
      loss_q      <= CNT_W'(0);
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      pll_fail_q  <= pll_fail_d;
    end
  end

  assign state         = state_q;
  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign pll_fail      = pll_fail_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Testbench for pll_lock_rst_seq. The driver issues randomized lock/restart
// scenarios and, from the sequencing rules, predicts every output change as
// (edge number, state, pll_rst, sys_rst_n, pll_fail, lock_loss_cnt). A
// monitor detects each output change on the falling edge and compares it
// against the next predicted change.
module tb_pll_lock_rst_seq;

  localparam int RST_C  = 16;
  localparam int TO_C   = 64;
  localparam int STB_C  = 32;
  localparam int NRETRY = 3;
  localparam int CW     = 4;
  localparam int LMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_lock;
  logic          sw_rst_req;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          pll_fail;
  logic [2:0]    state;
  logic [CW-1:0] lock_loss_cnt;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int loss_m = 0;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       pr;
    logic       sr;
    logic       pf;
    logic [CW-1:0] ll;
  } ev_t;

  ev_t exp_q[$];

  pll_lock_rst_seq #(
    .PLL_RST_CYC(RST_C), .LOCK_TIMEOUT_CYC(TO_C), .LOCK_STABLE_CYC(STB_C),
    .MAX_RETRY(NRETRY), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .pll_fail(pll_fail),
    .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic push(input int c, input int st, input bit pr, input bit sr, input bit pf, input int ll);
    ev_t e;
    e.cyc = c; e.st = 3'(st); e.pr = pr; e.sr = sr; e.pf = pf; e.ll = CW'(ll);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just before edge e,
  // so an input set afterwards is first sampled at edge e.
  task automatic go_to(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  // Lock first sampled high at W+d; STABLE cannot start before W+1.
  task automatic relock(input int w, input int lo, input int hi, output int r);
    int k2, s;
    k2 = w + rnd(lo, hi);
    s  = (k2 + 2 > w + 1) ? k2 + 2 : w + 1;
    r  = s + STB_C;
    push(s, 2, 1'b0, 1'b0, 1'b0, loss_m);
    push(r, 3, 1'b0, 1'b1, 1'b0, loss_m);
    go_to(k2);
    pll_lock = 1'b1;
  endtask

  // Lock first sampled low at edge k while running; FSM reacts at k+2.
  task automatic drop_lock(input int r, input bit inc, output int k, output int w);
    k = r + rnd(3, 20);
    if (inc) loss_m = (loss_m < LMAX) ? loss_m + 1 : LMAX;
    push(k + 2, 0, 1'b1, 1'b0, 1'b0, loss_m);
    w = k + 2 + RST_C;
    push(w, 1, 1'b0, 1'b0, 1'b0, loss_m);
    go_to(k);
    pll_lock = 1'b0;
  endtask

  // Monitor: every output change must match the next predicted change.
  initial begin : monitor
    logic [2:0] p_st;
    logic p_pr, p_sr, p_pf;
    logic [CW-1:0] p_ll;
    ev_t e;
    p_st = 3'd0; p_pr = 1'b1; p_sr = 1'b0; p_pf = 1'b0; p_ll = '0;
    forever begin
      @(negedge clk);
      if (state !== p_st || pll_rst !== p_pr || sys_rst_n !== p_sr ||
          pll_fail !== p_pf || lock_loss_cnt !== p_ll) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_change: cyc=%0d st=%0d rst=%b sys=%b fail=%b loss=%0d, required no change",
                   cyc, state, pll_rst, sys_rst_n, pll_fail, lock_loss_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.st !== state || e.pr !== pll_rst || e.sr !== sys_rst_n ||
              e.pf !== pll_fail || e.ll !== lock_loss_cnt) begin
            bad = bad + 1;
            $display("FAIL event: got cyc=%0d st=%0d rst=%b sys=%b fail=%b loss=%0d required cyc=%0d st=%0d rst=%b sys=%b fail=%b loss=%0d",
                     cyc, state, pll_rst, sys_rst_n, pll_fail, lock_loss_cnt,
                     e.cyc, e.st, e.pr, e.sr, e.pf, e.ll);
          end
        end
        p_st = state; p_pr = pll_rst; p_sr = sys_rst_n; p_pf = pll_fail; p_ll = lock_loss_cnt;
      end
    end
  end

  initial begin : watchdog
    #(1000000);
    $display("FAIL watchdog: simulation exceeded time budget at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin : driver
    int w, k, k2, s, s2, r, g, k3, c, n;
    rst_n = 1'b0; pll_lock = 1'b0; sw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_sys_rst_n", sys_rst_n, 0);
    chk("reset_pll_fail", pll_fail, 0);
    chk("reset_loss", lock_loss_cnt, 0);

    // Nominal power-up and lock.
    n = cyc; rst_n = 1'b1;
    w = n + RST_C;
    push(w, 1, 1'b0, 1'b0, 1'b0, loss_m);
    relock(w, 5, 40, r);
    chk("nominal_no_fail", pll_fail, 0);

    // Lock drop in RUN, then a 3-cycle glitch while in STABLE.
    drop_lock(r, 1'b1, k, w);
    k2 = w + rnd(1, 30);
    s  = k2 + 2;
    push(s, 2, 1'b0, 1'b0, 1'b0, loss_m);
    g  = s + 10;
    push(g + 2, 1, 1'b0, 1'b0, 1'b0, loss_m);
    k3 = g + 3;
    push(k3 + 2, 2, 1'b0, 1'b0, 1'b0, loss_m);
    r  = k3 + 2 + STB_C;
    push(r, 3, 1'b0, 1'b1, 1'b0, loss_m);
    go_to(k2); pll_lock = 1'b1;
    go_to(g);  pll_lock = 1'b0;
    go_to(k3); pll_lock = 1'b1;

    // Software restart on the same edge the FSM sees a RUN lock drop.
    drop_lock(r, 1'b0, k, w);
    go_to(k + 2); sw_rst_req = 1'b1;
    go_to(k + 3); sw_rst_req = 1'b0;
    relock(w, 1, 30, r);

    // Repeated lock losses, with relock sometimes already high in PLL_RST.
    for (int i = 0; i < 20; i++) begin
      drop_lock(r, 1'b1, k, w);
      relock(w, -10, 40, r);
    end
    go_to(r + 2);
    chk("loss_saturated", lock_loss_cnt, LMAX);

    // Lock never returns: three timeouts, then FAIL.
    drop_lock(r, 1'b1, k, w);
    push(w + TO_C,             0, 1'b1, 1'b0, 1'b0, loss_m);
    push(w + TO_C + RST_C,     1, 1'b0, 1'b0, 1'b0, loss_m);
    push(w + 2*TO_C + RST_C,   0, 1'b1, 1'b0, 1'b0, loss_m);
    push(w + 2*TO_C + 2*RST_C, 1, 1'b0, 1'b0, 1'b0, loss_m);
    push(w + 3*TO_C + 2*RST_C, 4, 1'b1, 1'b0, 1'b1, loss_m);
    s = w + 3*TO_C + 2*RST_C + rnd(5, 30);
    push(s, 0, 1'b1, 1'b0, 1'b0, loss_m);
    s2 = s + rnd(3, 10);
    push(s2 + RST_C, 1, 1'b0, 1'b0, 1'b0, loss_m);
    go_to(s);
    chk("fail_flag", pll_fail, 1);
    chk("fail_pll_rst", pll_rst, 1);
    chk("fail_state", state, 4);
    sw_rst_req = 1'b1;
    go_to(s + 1);  sw_rst_req = 1'b0;
    go_to(s2);     sw_rst_req = 1'b1;
    go_to(s2 + 1); sw_rst_req = 1'b0;
    relock(s2 + RST_C, 1, 40, r);

    // Software restart in RUN with lock held high.
    s = r + rnd(3, 10);
    push(s, 0, 1'b1, 1'b0, 1'b0, loss_m);
    w = s + RST_C;
    push(w, 1, 1'b0, 1'b0, 1'b0, loss_m);
    push(w + 1, 2, 1'b0, 1'b0, 1'b0, loss_m);
    r = w + 1 + STB_C;
    push(r, 3, 1'b0, 1'b1, 1'b0, loss_m);
    go_to(s);     sw_rst_req = 1'b1;
    go_to(s + 1); sw_rst_req = 1'b0;

    // Asynchronous reset between clock edges while in RUN.
    go_to(r + rnd(3, 10));
    c = cyc;
    #2;
    rst_n = 1'b0;
    loss_m = 0;
    push(c + 1, 0, 1'b1, 1'b0, 1'b0, 0);
    #1;
    chk("async_sys_rst_n", sys_rst_n, 0);
    chk("async_pll_rst", pll_rst, 1);
    chk("async_loss", lock_loss_cnt, 0);
    chk("async_state", state, 0);
    go_to(c + 5);
    n = cyc; rst_n = 1'b1;
    w = n + RST_C;
    push(w, 1, 1'b0, 1'b0, 1'b0, 0);
    push(w + 1, 2, 1'b0, 1'b0, 1'b0, 0);
    r = w + 1 + STB_C;
    push(r, 3, 1'b0, 1'b1, 1'b0, 0);
    go_to(r + 10);

    chk("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
